wave_reader: RTL

//  Read initiator for the synchronous 256x8 waveform ROM. Walks ROM addresses

---
 rtl/wave_reader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/wave_reader.sv
// wave_reader: read initiator for a 1-cycle-latency synchronous ROM, streaming samples on valid/ready.
// Optional feature macro WAVE_READER_LOOP_EN adds a `loop` input that replays the programmed pass gaplessly.
module wave_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
`ifdef WAVE_READER_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   start_addr_r, stride_r;
    logic [ADDR_W:0]     len_full_r, remaining_r;
    logic                restart_r;
    logic                issue_r;
    logic                rd_r;
    logic [DATA_W-1:0]   fifo_mem_r [0:1];
    logic                fifo_wp_r, fifo_rp_r;
    logic [1:0]          fifo_cnt_r;

    logic                loop_s;
    logic [ADDR_W:0]     len_full_s, cnt_base_s, cnt_next_s;
    logic                reload_s;
    logic                start_issue_s, run_issue_s, any_issue_s;
    logic [ADDR_W-1:0]   addr_next_s;
    logic                out_free_s, fifo_pop_s, fifo_push_s, last_hs_s;
    logic [2:0]          occupancy_s;
    logic                busy_s, done_s;

`ifdef WAVE_READER_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = 1'b0;
`endif

    // Issue control. smp_data is itself a storage slot ahead of the 2-entry FIFO, so the
    // outstanding budget (held output + FIFO + both ROM pipeline stages) is capped at three.
    always_comb begin
        len_full_s    = (length == {ADDR_W{1'b0}}) ? CNT_FULL : {1'b0, length};
        out_free_s    = ~smp_valid | smp_ready;
        fifo_pop_s    = out_free_s & (fifo_cnt_r != 2'd0);
        fifo_push_s   = rd_r & ~(out_free_s & (fifo_cnt_r == 2'd0));
        occupancy_s   = {2'b00, smp_valid & ~smp_ready} + {1'b0, fifo_cnt_r}
                      + {2'b00, rd_r} + {2'b00, issue_r};
        start_issue_s = (state_r == IDLE) & start & ~abort;
        run_issue_s   = (state_r == RUN) & ~abort & (remaining_r != CNT_ZERO)
                      & (occupancy_s < 3'd3);
        any_issue_s   = start_issue_s | run_issue_s;
        last_hs_s     = smp_valid & smp_ready & (fifo_cnt_r == 2'd0) & ~rd_r & ~issue_r;
        if (start_issue_s) begin
            cnt_base_s  = len_full_s;
            addr_next_s = start_addr;
        end else if (restart_r) begin
            cnt_base_s  = remaining_r;
            addr_next_s = start_addr_r;
        end else begin
            cnt_base_s  = remaining_r;
            addr_next_s = mem_addr + stride_r;
        end
        reload_s = loop_s & (cnt_base_s == CNT_ONE);
        if (reload_s) begin
            cnt_next_s = start_issue_s ? len_full_s : len_full_r;
        end else begin
            cnt_next_s = cnt_base_s - CNT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (abort)      state_s = IDLE;
                else if (start) state_s = RUN;
                else            state_s = IDLE;
            end
            RUN: begin
                if (abort)                          state_s = IDLE;
                else if (remaining_r == CNT_ZERO)   state_s = DRAIN;
                else                                state_s = RUN;
            end
            DRAIN: begin
                if (abort)          state_s = IDLE;
                else if (last_hs_s) state_s = IDLE;
                else                state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs, registered below.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            RUN, DRAIN: busy_s = 1'b1;
            default:    busy_s = 1'b0;
        endcase
        if ((state_r == DRAIN) && !abort && last_hs_s) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Address walker, remaining counter and ROM pipeline tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= {ADDR_W{1'b0}};
            start_addr_r <= {ADDR_W{1'b0}};
            stride_r     <= {ADDR_W{1'b0}};
            len_full_r   <= CNT_ZERO;
            remaining_r  <= CNT_ZERO;
            restart_r    <= 1'b0;
            issue_r      <= 1'b0;
            rd_r         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= done_s;
            if (abort) begin
                remaining_r <= CNT_ZERO;
                restart_r   <= 1'b0;
                issue_r     <= 1'b0;
                rd_r        <= 1'b0;
            end else begin
                rd_r <= issue_r;
                if (start_issue_s) begin
                    start_addr_r <= start_addr;
                    stride_r     <= stride;
                    len_full_r   <= len_full_s;
                end else begin
                    start_addr_r <= start_addr_r;
                end
                if (any_issue_s) begin
                    mem_addr    <= addr_next_s;
                    remaining_r <= cnt_next_s;
                    restart_r   <= reload_s;
                    issue_r     <= 1'b1;
                end else begin
                    issue_r <= 1'b0;
                end
            end
        end
    end

    // Sample buffer: output register fed from the FIFO, or straight from the ROM when the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_data      <= {DATA_W{1'b0}};
            smp_valid     <= 1'b0;
            fifo_mem_r[0] <= {DATA_W{1'b0}};
            fifo_mem_r[1] <= {DATA_W{1'b0}};
            fifo_wp_r     <= 1'b0;
            fifo_rp_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else if (abort) begin
            smp_valid  <= 1'b0;
            fifo_wp_r  <= 1'b0;
            fifo_rp_r  <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            if (fifo_pop_s) begin
                smp_data  <= fifo_mem_r[fifo_rp_r];
                smp_valid <= 1'b1;
                fifo_rp_r <= ~fifo_rp_r;
            end else if (out_free_s && rd_r) begin
                smp_data  <= mem_data;
                smp_valid <= 1'b1;
            end else if (out_free_s) begin
                smp_valid <= 1'b0;
            end else begin
                smp_valid <= smp_valid;
            end
            if (fifo_push_s) begin
                fifo_mem_r[fifo_wp_r] <= mem_data;
                fifo_wp_r             <= ~fifo_wp_r;
            end else begin
                fifo_wp_r <= fifo_wp_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, fifo_push_s} - {1'b0, fifo_pop_s};
        end
    end

endmodule
